// File: rtl/dff_stim_tx_if.sv
// Bus between the D flip-flop stimulus transmitter and its user / flip-flop side.
// The master drives the request and the flip-flop response; the slave is the transmitter.
interface dff_stim_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic             D_out;
    logic             C_out;
    logic             Q_in;
    logic             nQ_in;
    logic [WIDTH-1:0] qword;
    logic             err;
    logic [7:0]       err_cnt;

    modport master (
        output start, din, Q_in, nQ_in,
        input  busy, done, D_out, C_out, qword, err, err_cnt
    );

    modport slave (
        input  start, din, Q_in, nQ_in,
        output busy, done, D_out, C_out, qword, err, err_cnt
    );
endinterface

// File: rtl/dff_stim_tx.sv
// Serialises a word MSB-first onto a flip-flop's D pin with a programmable C strobe,
// samples Q/nQ at the end of each strobe and reports the captured word and error counts.
module dff_stim_tx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SETUP = 2,
    parameter int unsigned HIGH  = 2,
    parameter int unsigned LOW   = 2
) (
    input  logic             C,
    input  logic             R,
    dff_stim_tx_if.slave     bus
);
    localparam int unsigned PMAX0 = (SETUP > HIGH) ? SETUP : HIGH;
    localparam int unsigned PMAX  = (PMAX0 > LOW) ? PMAX0 : LOW;
    localparam int unsigned CW    = (PMAX > 1) ? $clog2(PMAX) : 1;
    localparam int unsigned IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLow, StDone} state_e;

    state_e           r_state, w_state_d;
    logic [CW-1:0]    r_cnt, w_cnt_d;
    logic [IW-1:0]    r_idx, w_idx_d;
    logic [WIDTH-1:0] r_shift, w_shift_d;
    logic [WIDTH-1:0] r_qword, w_qword_d;
    logic             r_busy, w_busy_d;
    logic             r_done, w_done_d;
    logic             r_dout, w_dout_d;
    logic             r_cout, w_cout_d;
    logic             r_werr, w_werr_d;
    logic             r_err, w_err_d;
    logic [7:0]       r_err_cnt, w_err_cnt_d;
    logic             w_mismatch;

    // Q==nQ fails one of the two terms whatever the driven bit is.
    assign w_mismatch = (bus.Q_in != r_dout) || (bus.nQ_in == r_dout);

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_idx_d     = r_idx;
        w_shift_d   = r_shift;
        w_qword_d   = r_qword;
        w_busy_d    = r_busy;
        w_done_d    = 1'b0;
        w_dout_d    = r_dout;
        w_cout_d    = r_cout;
        w_werr_d    = r_werr;
        w_err_d     = r_err;
        w_err_cnt_d = r_err_cnt;

        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_shift_d = bus.din;
                    w_idx_d   = IW'(WIDTH - 1);
                    w_dout_d  = bus.din[WIDTH-1];
                    w_werr_d  = 1'b0;
                    w_qword_d = '0;
                    w_busy_d  = 1'b1;
                    w_cnt_d   = '0;
                    w_state_d = StSetup;
                end
            end
            StSetup: begin
                if (r_cnt == CW'(SETUP - 1)) begin
                    w_cnt_d   = '0;
                    w_cout_d  = 1'b1;
                    w_state_d = StHigh;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StHigh: begin
                if (r_cnt == CW'(HIGH - 1)) begin
                    w_qword_d = (r_qword << 1) | WIDTH'(bus.Q_in);
                    if (w_mismatch) begin
                        w_werr_d = 1'b1;
                        if (r_err_cnt != 8'hFF) begin
                            w_err_cnt_d = r_err_cnt + 8'd1;
                        end
                    end
                    w_cnt_d   = '0;
                    w_cout_d  = 1'b0;
                    w_state_d = StLow;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StLow: begin
                if (r_cnt == CW'(LOW - 1)) begin
                    w_cnt_d = '0;
                    if (r_idx != '0) begin
                        w_idx_d   = r_idx - 1'b1;
                        w_dout_d  = r_shift[r_idx - 1'b1];
                        w_state_d = StSetup;
                    end else begin
                        w_done_d  = 1'b1;
                        w_err_d   = r_werr;
                        w_dout_d  = 1'b0;
                        w_state_d = StDone;
                    end
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StDone: begin
                w_busy_d  = 1'b0;
                w_state_d = StIdle;
            end
            default: begin
                w_busy_d  = 1'b0;
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_qword   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dout    <= 1'b0;
            r_cout    <= 1'b0;
            r_werr    <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_idx     <= w_idx_d;
            r_shift   <= w_shift_d;
            r_qword   <= w_qword_d;
            r_busy    <= w_busy_d;
            r_done    <= w_done_d;
            r_dout    <= w_dout_d;
            r_cout    <= w_cout_d;
            r_werr    <= w_werr_d;
            r_err     <= w_err_d;
            r_err_cnt <= w_err_cnt_d;
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.D_out   = r_dout;
    assign bus.C_out   = r_cout;
    assign bus.qword   = r_qword;
    assign bus.err     = r_err;
    assign bus.err_cnt = r_err_cnt;
endmodule

// File: tb/tb_dff_stim_tx.sv
// Bench for dff_stim_tx: random words against ideal, stuck, shorted and inverting flip-flop
// responses, with a word-level reference model of captured data and error counting.
module tb_dff_stim_tx;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned BITCYC = 6;

    logic C = 1'b0;
    logic R = 1'b1;
    int   checks = 0;
    int   failures = 0;

    // Flip-flop response selector: 0 ideal DFF, 1 Q stuck 0, 2 Q=nQ=1, 3 inverted DFF.
    int   mode = 0;
    logic dff_q = 1'b0;
    logic dff_d;
    int   m_cnt = 0;
    int   rises = 0;
    int   viol = 0;
    logic prev_c = 1'b0;
    logic prev_d = 1'b0;

    dff_stim_tx_if #(.WIDTH(WIDTH)) bus ();

    dff_stim_tx #(.WIDTH(WIDTH), .SETUP(2), .HIGH(2), .LOW(2)) dut (
        .C   (C),
        .R   (R),
        .bus (bus)
    );

    always #5 C = ~C;

    always @(posedge bus.C_out) begin
        dff_d = bus.D_out;
        #1 dff_q = dff_d;
    end

    assign bus.Q_in  = (mode == 0) ? dff_q : (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : ~dff_q;
    assign bus.nQ_in = (mode == 0) ? ~dff_q : (mode == 1) ? 1'b1 : (mode == 2) ? 1'b1 : dff_q;

    always @(negedge C) begin
        if (bus.C_out && !prev_c) rises++;
        if (bus.C_out && prev_c && (bus.D_out != prev_d)) viol++;
        prev_c = bus.C_out;
        prev_d = bus.D_out;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_word(input logic [7:0] d, input int md,
                              output logic [7:0] q, output int e);
        case (md)
            0:       begin q = d;     e = 0;              end
            1:       begin q = 8'h00; e = $countones(d);  end
            2:       begin q = 8'hFF; e = WIDTH;          end
            default: begin q = ~d;    e = WIDTH;          end
        endcase
    endtask

    task automatic run_word(input logic [7:0] d, input int md, input bit noise);
        logic [7:0] exp_q;
        int         exp_e;
        int         busy_cyc;
        int         r0;
        bit         got;
        mode = md;
        @(negedge C);
        bus.start = 1'b1;
        bus.din   = d;
        @(negedge C);
        bus.start = 1'b0;
        bus.din   = 8'($urandom);
        r0 = rises;
        busy_cyc = 0;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            if (bus.busy) busy_cyc++;
            if (noise) bus.start = 1'($urandom_range(0, 1));
            @(negedge C);
        end
        check_eq("done_seen", 32'(got), 32'd1);
        if (got) begin
            model_word(d, md, exp_q, exp_e);
            m_cnt = (m_cnt + exp_e > 255) ? 255 : m_cnt + exp_e;
            check_eq("busy_cycles", busy_cyc, WIDTH * BITCYC);
            check_eq("qword", 32'(bus.qword), 32'(exp_q));
            check_eq("err", 32'(bus.err), (exp_e != 0) ? 32'd1 : 32'd0);
            check_eq("err_cnt", 32'(bus.err_cnt), m_cnt);
            check_eq("strobes", rises - r0, WIDTH);
            // A start in the DONE cycle must not be accepted.
            bus.start = noise;
            @(negedge C);
            bus.start = 1'b0;
            check_eq("idle_busy", 32'(bus.busy), 32'd0);
            check_eq("done_pulse", 32'(bus.done), 32'd0);
            @(negedge C);
            check_eq("still_idle", 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int         dn[$];
        int         cyc;
        logic [7:0] d;
        bus.start = 1'b0;
        bus.din   = '0;
        repeat (2) @(negedge C);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_cout", 32'(bus.C_out), 32'd0);
        check_eq("rst_errcnt", 32'(bus.err_cnt), 32'd0);
        check_eq("rst_qword", 32'(bus.qword), 32'd0);
        R = 1'b0;

        run_word(8'hA5, 0, 1'b0);
        run_word(8'hFF, 1, 1'b0);
        run_word(8'h00, 1, 1'b0);
        run_word(8'h0F, 2, 1'b0);
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom);
            run_word(d, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Held start: back-to-back words, one IDLE cycle between DONE and next accept.
        mode = 0;
        @(negedge C);
        bus.start = 1'b1;
        bus.din   = 8'h5A;
        cyc = 0;
        while (dn.size() < 3 && cyc < 400) begin
            @(negedge C);
            cyc++;
            if (bus.done) begin
                dn.push_back(cyc);
                check_eq("btb_qword", 32'(bus.qword), 32'h5A);
                if (dn.size() == 3) bus.start = 1'b0;
            end
        end
        check_eq("btb_count", dn.size(), 3);
        if (dn.size() == 3) begin
            check_eq("btb_gap1", dn[1] - dn[0], WIDTH * BITCYC + 2);
            check_eq("btb_gap2", dn[2] - dn[1], WIDTH * BITCYC + 2);
        end
        @(negedge C);
        check_eq("btb_errcnt", 32'(bus.err_cnt), m_cnt);

        for (int i = 0; i < 33; i++) run_word(8'hFF, 1, 1'b0);
        check_eq("sat_errcnt", 32'(bus.err_cnt), 32'd255);

        // Abort in the HIGH phase of bit index 3.
        mode = 0;
        @(negedge C);
        bus.start = 1'b1;
        bus.din   = 8'hA5;
        @(negedge C);
        bus.start = 1'b0;
        repeat (26) @(negedge C);
        check_eq("abort_in_high", 32'(bus.C_out), 32'd1);
        #2 R = 1'b1;
        #1;
        check_eq("abort_cout", 32'(bus.C_out), 32'd0);
        check_eq("abort_dout", 32'(bus.D_out), 32'd0);
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        check_eq("abort_done", 32'(bus.done), 32'd0);
        check_eq("abort_err", 32'(bus.err), 32'd0);
        check_eq("abort_errcnt", 32'(bus.err_cnt), 32'd0);
        check_eq("abort_qword", 32'(bus.qword), 32'd0);
        @(negedge C);
        R = 1'b0;
        m_cnt = 0;
        run_word(8'h3C, 0, 1'b0);

        check_eq("d_stable_high", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dff_stim_tx.md
Name: dff_stim_tx

Overview:
- Synchronous transmitter that drives the D/C pin pair of a gate-level D flip-flop under test and reads back its Q/nQ pair.
- Takes a parallel word, serialises it MSB-first onto D_out, and generates a programmable strobe on C_out.
- Samples the DUT response once per bit and returns the captured word, a per-word error flag and a cumulative error count.
- Sits in benches and self-test wrappers as the write-side counterpart of the flip-flop.

Parameters:
WIDTH, 8, bits per word
SETUP, 2, cycles D_out is stable with C_out low before strobe rise (>=1)
HIGH, 2, cycles C_out is held high (>=1)
LOW, 2, cycles C_out is held low after the high phase (>=1)

Ports:
C  input  1  system clock, rising edge
R  input  1  reset, asynchronous, active-high
start  input  1  request to transmit din; accepted only in IDLE
din  input  WIDTH  word to transmit, captured on the accepting edge
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at word completion
D_out  output  1  data to DUT D pin
C_out  output  1  strobe to DUT C pin
Q_in  input  1  DUT Q
nQ_in  input  1  DUT nQ
qword  output  WIDTH  captured Q samples, MSB-first; valid while done=1 and held until next accept
err  output  1  1 if any bit of the last word mismatched; updated with done
err_cnt  output  8  cumulative mismatching bits since reset, saturates at 255

Behaviour:
- Reset (async, R=1): state IDLE; busy=0, done=0, D_out=0, C_out=0, qword=0, err=0, err_cnt=0, bit index=0. Outputs clear immediately, not at the next edge.
- Reset asserted mid-word aborts the transfer; the partial qword is discarded.
- All outputs are registered; no combinational path from any input to any output.
- FSM states: IDLE, SETUP, HIGH, LOW, DONE.
  - IDLE: on start=1, latch din into shift reg, set bit index=WIDTH-1, D_out=din[WIDTH-1], clear word error flag, go to SETUP.
  - SETUP: C_out=0 for SETUP cycles, then C_out<=1, go to HIGH.
  - HIGH: C_out=1 for HIGH cycles.
    - On the last HIGH cycle edge, sample Q_in/nQ_in: qword shifts left taking Q_in.
    - Mismatch if Q_in!=bit or nQ_in!=~bit. Q_in==nQ_in is always a mismatch.
    - On mismatch: set word error flag; err_cnt+=1 unless already 255.
    - Then C_out<=0, go to LOW.
  - LOW: C_out=0 for LOW cycles.
    - If bit index>0: decrement it, D_out<=next bit, go to SETUP.
    - Else go to DONE.
  - DONE: done=1 for exactly one cycle; err<=word error flag; D_out<=0; then IDLE.
- Timing: one bit takes SETUP+HIGH+LOW cycles. The word takes WIDTH*(SETUP+HIGH+LOW) cycles plus one DONE cycle.
- busy rises the cycle after start is accepted. Earliest next accept is the cycle after DONE.
- start while busy (including during DONE) is ignored, not queued. din is ignored outside the accepting edge.
- D_out changes only on SETUP entry and in DONE, never while C_out=1.
- Phase counters are sized to max(SETUP,HIGH,LOW); the bit index is sized to clog2(WIDTH) with a minimum of 1.

Test Plan:
- Loopback to an ideal edge DFF model (1 time-unit delay), WIDTH=8, S=H=L=2, din=0xA5. Required: 48 busy cycles, then done pulse; qword=0xA5, err=0, err_cnt=0. D_out is stable for every C_out high window.
- Q_in stuck at 0, nQ_in=~Q_in, din=0xFF -> qword=0x00, err=1, err_cnt=8. Next word din=0x00 -> err=0, err_cnt stays 8.
- Q_in=nQ_in=1 forced, din=0x0F -> err=1, err_cnt increments by 8.
- Error saturation: 33 words of 0xFF with Q_in stuck at 0 -> err_cnt reaches 255 and holds.
- start pulses during busy and in the DONE cycle -> ignored; exactly one done per accepted start. start held high continuously -> back-to-back words with one IDLE cycle between them.
- R asserted during HIGH of bit 3 -> C_out, D_out, busy, done, err, err_cnt and qword go to 0 immediately. After release, a new start with din=0x3C completes with qword=0x3C.
